// File: rtl/fifo_stream_reader.sv
// Read-side engine for a 1-cycle-latency FIFO: a 2-entry skid buffer feeds a valid/ready stream master
// with fixed-length packet framing and a beat counter. Optional sequence checker: FIFO_RD_SEQ_CHECK_EN.
module fifo_stream_reader #(
  parameter int DW      = 16,
  parameter int PKT_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rstp,
  input  logic [DW-1:0]    fifo_dout,
  input  logic             fifo_emptyp,
  output logic             fifo_readp,
  output logic [DW-1:0]    m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [CNT_W-1:0] word_cnt,
  output logic             seq_err
);

  localparam int            BW        = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);

  logic [1:0]    occ;
  logic          rd_pend;
  logic [DW-1:0] head_q;
  logic [DW-1:0] tail_q;
  logic [BW-1:0] beat;
  logic          pop;
  logic [2:0]    level;

  assign m_tvalid = (occ != 2'd0);
  assign m_tdata  = head_q;
  assign m_tlast  = m_tvalid & (beat == LAST_BEAT);
  assign pop      = m_tvalid & m_tready;

  // Occupancy the buffer would reach counting the read already in flight; pop
  // is only possible when occ>0, so this never goes negative.
  assign level      = 3'(occ) + 3'(rd_pend) - 3'(pop);
  assign fifo_readp = ~fifo_emptyp & (level < 3'd2);

  // NOTE: both data entries are reset as well so m_tdata reads 0 out of reset;
  // this is a 2-word buffer, not a RAM, so resetting it costs nothing.
  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      occ     <= 2'd0;
      rd_pend <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      rd_pend <= fifo_readp;
      case ({rd_pend, pop})
        2'b10: begin
          if (occ == 2'd0) head_q <= fifo_dout;
          else             tail_q <= fifo_dout;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_q <= tail_q;
          occ    <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            head_q <= tail_q;
            tail_q <= fifo_dout;
          end else begin
            head_q <= fifo_dout;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      beat     <= '0;
      word_cnt <= '0;
    end else if (pop) begin
      beat     <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

`ifdef FIFO_RD_SEQ_CHECK_EN
  logic [DW-1:0] last_popped;
  logic          have_last;
  logic          seq_err_q;

  // The first accepted beat after reset only seeds the reference value.
  always_ff @(posedge clk or posedge rstp) begin
    if (rstp) begin
      last_popped <= '0;
      have_last   <= 1'b0;
      seq_err_q   <= 1'b0;
    end else if (pop) begin
      last_popped <= m_tdata;
      have_last   <= 1'b1;
      if (have_last && (m_tdata != last_popped + DW'(1))) seq_err_q <= 1'b1;
    end
  end

  assign seq_err = seq_err_q;
`else
  assign seq_err = 1'b0;
`endif

endmodule
